// File: rtl/bcd_disp_pkg.sv
// Shared display definitions for the BCD scan counter.
// Holds the active-low 7-segment patterns (bit 6 = g ... bit 0 = a) for the
// decimal codes 0-9, the blank pattern, and the code-to-segment decoder.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Codes 10-15 cannot occur in a stored digit, but they still decode to a
  // dark digit rather than to a garbage pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter.
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   inc, dec    - step this digit up / down (never both asserted)
//   load        - synchronous load of load_d (codes above 9 store as 0)
//   load_d      - digit value to load
//   d           - stored digit, registered
//   co          - carry out: incrementing while at 9 (rolls the next digit)
//   bo          - borrow out: decrementing while at 0 (rolls the next digit)
module bcd_digit
  import bcd_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] d,
  output logic       co,
  output logic       bo
);

  // co/bo are combinational so a whole carry chain ripples within one cycle.
  assign co = inc && (d == 4'd9);
  assign bo = dec && (d == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= 4'd0;
    end else if (load) begin
      d <= (load_d > 4'd9) ? 4'd0 : load_d;
    end else if (inc) begin
      d <= co ? 4'd0 : d + 4'd1;
    end else if (dec) begin
      d <= bo ? 4'd9 : d - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter driving a common-anode multiplexed
// 7-segment display.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   en         - count enable, gates the tick prescaler
//   up_dn      - 1 = count up, 0 = count down
//   load       - synchronous load of load_val (wins over a tick)
//   load_val   - BCD load value, digit i at [4i+3:4i]
//   bcd        - current count, registered
//   carry      - one-cycle pulse when the count wraps in either direction
//   y          - segments, active-low, bit 6 = g ... bit 0 = a
//   control    - anode selects, active-low, one digit at a time
module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [6:0]            y,
  output logic [DIGITS-1:0]     control
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic              step_up;
  logic              step_dn;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] bo;

  logic [SW-1:0]     scan_cnt;
  logic              scan_wrap;
  logic [IW-1:0]     scan_idx;
  logic [IW-1:0]     idx_nxt;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  logic [3:0]        sel_digit;
  logic [6:0]        seg_nxt;

  // ---- Stage: count-step prescaler ----
  // With TICK_DIV = 1 the counter never leaves 0, so tick simply follows en.
  assign tick = en && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (load || tick) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // ---- Stage: decade chain ----
  // A load discards a coincident tick, so the chain only sees a step when
  // load is low.
  assign step_up = tick && up_dn && !load;
  assign step_dn = tick && !up_dn && !load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign inc[g] = step_up;
      assign dec[g] = step_dn;
    end else begin : g_upper
      assign inc[g] = co[g-1];
      assign dec[g] = bo[g-1];
    end

    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc[g]),
      .dec    (dec[g]),
      .load   (load),
      .load_d (load_val[4*g +: 4]),
      .d      (bcd[4*g +: 4]),
      .co     (co[g]),
      .bo     (bo[g])
    );
  end

  // The top digit rolling over means every digit rolled: that is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else begin
      carry <= co[DIGITS-1] || bo[DIGITS-1];
    end
  end

  // ---- Stage: scan prescaler and digit index ----
  always_comb begin
    scan_wrap = (scan_cnt == SCAN_LAST);
    idx_nxt   = scan_idx;
    if (scan_wrap) begin
      idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      scan_idx <= idx_nxt;
    end
  end

  // ---- Stage: segment/anode output registers ----
  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so a zero count still reads "0".
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (bcd[4*k +: 4] == 4'd0);
      blank[k]   = (LZB != 0) && (k > 0) && upper_zero;
    end
  end

  // The output registers are driven from the index being loaded this edge,
  // so control always matches the scan index register.
  always_comb begin
    sel_digit = bcd[4*int'(idx_nxt) +: 4];
    seg_nxt   = blank[idx_nxt] ? SEG_BLANK : seg_decode(sel_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= SEG_0;
      control <= ~DIGITS'(1);
    end else begin
      y       <= seg_nxt;
      control <= ~(DIGITS'(1) << idx_nxt);
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;

  logic [15:0] bcd0, bcd1;
  logic        carry0, carry1;
  logic [6:0]  y0, y1;
  logic [3:0]  control0, control1;

  int tests  = 0;
  int failed = 0;

  // behavioural model state: count as a plain integer 0..9999
  int         m_val, m_pre, m_scnt, m_sidx;
  logic       m_carry;
  logic [6:0] m_y0, m_y1;
  logic [3:0] m_ctl;

  logic [6:0] seg_tab [10];

  typedef struct {
    logic [15:0] lv;
    logic        up;
    int          ticks;
    logic [15:0] exp_bcd;
    int          exp_carries;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .LZB(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd(bcd0), .carry(carry0), .y(y0), .control(control0)
  );

  bcd_scan_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .LZB(1)) u_lzb (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd(bcd1), .carry(carry1), .y(y1), .control(control1)
  );

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic int decode_load(input logic [15:0] lv);
    int v = 0;
    int nib;
    for (int i = 3; i >= 0; i--) begin
      nib = int'(lv[4*i +: 4]);
      v = v * 10 + ((nib > 9) ? 0 : nib);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("bcd",         32'(bcd0),     32'(to_bcd(m_val)));
    check("carry",       32'(carry0),   32'(m_carry));
    check("y",           32'(y0),       32'(m_y0));
    check("control",     32'(control0), 32'(m_ctl));
    check("bcd_lzb",     32'(bcd1),     32'(to_bcd(m_val)));
    check("carry_lzb",   32'(carry1),   32'(m_carry));
    check("y_lzb",       32'(y1),       32'(m_y1));
    check("control_lzb", 32'(control1), 32'(m_ctl));
  endtask

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_scnt = 0; m_sidx = 0;
    m_carry = 1'b0;
    m_y0 = seg_tab[0];
    m_y1 = seg_tab[0];
    m_ctl = 4'b1110;
  endtask

  // one clock: update the model from the pre-edge state and inputs, then compare
  task automatic cycle();
    int   old;
    int   d;
    logic m_tick;
    @(posedge clk);
    old = m_val;
    m_tick = en && (m_pre == TD - 1);
    if (load) begin
      m_val = decode_load(load_val);
      m_pre = 0;
      m_carry = 1'b0;
    end else if (m_tick) begin
      m_pre = 0;
      if (up_dn) begin
        m_carry = (old == 9999);
        m_val = (old + 1) % 10000;
      end else begin
        m_carry = (old == 0);
        m_val = (old + 9999) % 10000;
      end
    end else begin
      m_carry = 1'b0;
      if (en) m_pre++;
    end
    if (m_scnt == SD - 1) begin
      m_scnt = 0;
      m_sidx = (m_sidx + 1) % 4;
    end else begin
      m_scnt++;
    end
    m_ctl = 4'b1111;
    m_ctl[m_sidx] = 1'b0;
    d = (old / pow10(m_sidx)) % 10;
    m_y0 = seg_tab[d];
    m_y1 = (m_sidx > 0 && old < pow10(m_sidx)) ? 7'b1111111 : seg_tab[d];
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int          ncarry;
    logic [15:0] rv;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{16'h9998, 1'b1, 1, 16'h9999, 0};
    vecs[1] = '{16'h9998, 1'b1, 2, 16'h0000, 1};
    vecs[2] = '{16'h1000, 1'b0, 1, 16'h0999, 0};
    vecs[3] = '{16'h0000, 1'b0, 1, 16'h9999, 1};
    vecs[4] = '{16'h0123, 1'b1, 5, 16'h0128, 0};
    vecs[5] = '{16'h12F7, 1'b1, 0, 16'h1207, 0};
    vecs[6] = '{16'h0990, 1'b0, 3, 16'h0987, 0};
    vecs[7] = '{16'h0009, 1'b1, 1, 16'h0010, 0};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    #22;
    rst_n = 1'b1;
    #1;
    // reset state, en = 0
    compare_all();
    check("rst_control", 32'(control0), 32'h0000000E);
    check("rst_y",       32'(y0),       32'h00000040);
    run(2);
    check("scan_after2", 32'(control0), 32'h0000000D);
    run(6);
    check("scan_after8", 32'(control0), 32'h0000000E);
    check("bcd_idle",    32'(bcd0),     32'h00000000);

    // table-driven load/count vectors
    for (int v = 0; v < 8; v++) begin
      en = 1'b1; up_dn = vecs[v].up; load = 1'b1; load_val = vecs[v].lv;
      cycle();
      load = 1'b0;
      ncarry = 0;
      for (int c = 0; c < vecs[v].ticks * TD; c++) begin
        cycle();
        if (carry0) ncarry++;
      end
      check($sformatf("vec%0d_bcd", v), 32'(bcd0), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_carries", v), 32'(ncarry), 32'(vecs[v].exp_carries));
    end

    // load coinciding with a tick: load wins, prescaler restarts
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 16'h9998;
    cycle();
    load = 1'b0;
    run(3);
    load = 1'b1; load_val = 16'h12F7;
    cycle();
    load = 1'b0;
    check("ldtick_bcd",   32'(bcd0),   32'h00001207);
    check("ldtick_carry", 32'(carry0), 32'h0);
    run(3);
    check("ldtick_hold",  32'(bcd0),   32'h00001207);
    cycle();
    check("ldtick_next",  32'(bcd0),   32'h00001208);

    // enable stall mid-prescale
    load = 1'b1; load_val = 16'h0000;
    cycle();
    load = 1'b0;
    run(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_hold", 32'(bcd0), 32'h0);
    end
    en = 1'b1;
    cycle();
    check("stall_pre_tick", 32'(bcd0), 32'h0);
    cycle();
    check("stall_tick", 32'(bcd0), 32'h00000001);

    // leading-zero blanking on 0040
    en = 1'b0; load = 1'b1; load_val = 16'h0040;
    cycle();
    load = 1'b0;
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      case (control1)
        4'b0111: check("lzb_d3", 32'(y1), 32'h0000007F);
        4'b1011: check("lzb_d2", 32'(y1), 32'h0000007F);
        4'b1101: check("lzb_d1", 32'(y1), 32'h00000019);
        4'b1110: check("lzb_d0", 32'(y1), 32'h00000040);
        default: check("lzb_onehot", 32'(control1), 32'(m_ctl));
      endcase
    end

    // asynchronous reset mid-scan
    run(3);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check("arst_y_lzb", 32'(y1), 32'h00000040);
    #2;
    rst_n = 1'b1;
    run(2);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) == 1;
      load  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: rv = 16'h9997;
        1: rv = 16'h0002;
        default: rv = 16'($urandom());
      endcase
      load_val = rv;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised multi-digit decimal (BCD) counter that drives a common-anode multiplexed 7-segment display.
- Adds to the single-digit mod-10 display counter: N digits, an up/down mode, synchronous load, a count-enable prescaler, time-multiplexed digit scanning and optional leading-zero blanking.
- Sits between the board clock and the display pins; `bcd` and `carry` are also exported to other logic.

Parameters:
- DIGITS, 4: number of BCD digits and anode lines; legal range 1..8.
- TICK_DIV, 50000000: clk cycles per count step; must be ≥ 1.
- SCAN_DIV, 50000: clk cycles per displayed digit; must be ≥ 1.
- LZB, 0: 1 = blank leading zero digits. The least significant digit (digit 0) is never blanked.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous reset, active-low.
- en, in, 1: count enable. Gates the tick prescaler.
- up_dn, in, 1: 1 = count up, 0 = count down.
- load, in, 1: synchronous load of load_val.
- load_val, in, 4*DIGITS: BCD load value. Digit i is bits [4i+3:4i].
- bcd, out, 4*DIGITS: current count, registered.
- carry, out, 1: one-cycle pulse on wrap in either direction.
- y, out, 7: segments, active-low. Bit 6 = g … bit 0 = a.
- control, out, DIGITS: anode selects, active-low, one-hot-zero.

Behaviour:
- Reset (rst_n low, asynchronous) sets all of the following:
  - bcd = 0; carry = 0.
  - Tick prescaler = 0; scan prescaler = 0; scan index = 0.
  - control = all ones except bit 0 low (DIGITS = 4 gives 1110).
  - y = 1000000.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 only while en = 1; holds its value while en = 0.
  - tick is asserted (internal, one cycle) when the prescaler is at TICK_DIV-1 with en = 1. The prescaler returns to 0 on that same edge.
  - With TICK_DIV = 1, tick = en every cycle.
- Count update on a rising edge, in priority order:
  1. load: bcd ← load_val. Any loaded digit > 9 is stored as 0. The tick prescaler clears to 0. carry = 0.
  2. tick and up_dn = 1, counting up:
     - Digit 0 increments. Digit i increments only when all lower digits were 9. A digit at 9 that increments becomes 0.
     - All digits at 9 → all digits 0, and carry = 1 for exactly one cycle.
  3. tick and up_dn = 0, counting down:
     - Digit 0 decrements. Digit i decrements only when all lower digits were 0. A digit at 0 that decrements becomes 9.
     - All digits at 0 → all digits 9, and carry = 1 for exactly one cycle.
  4. Otherwise bcd holds and carry = 0.
- Latency: bcd and carry change on the same edge that consumes the tick or load.
- Simultaneous events:
  - load together with tick: load wins and the tick is discarded.
  - up_dn changing mid-prescale: takes effect at the next tick; no glitch.
- Scan logic:
  - The scan prescaler counts 0..SCAN_DIV-1 freely; it is not gated by en.
  - At terminal count the scan index advances, wrapping from DIGITS-1 back to 0.
- Display outputs:
  - y and control are registered. Both are recomputed every cycle from the current scan index and the current bcd.
  - A bcd change is therefore visible on y one cycle later.
  - control = bitwise NOT of (1 << index).
- Segment table, active-low, for codes 0–9:

      0 = 1000000    1 = 1111001    2 = 0100100    3 = 0110000    4 = 0011001
      5 = 0010010    6 = 0000010    7 = 1111000    8 = 0000000    9 = 0010000

  - Codes 10–15 (unreachable) display 1111111 (blank).
- Leading-zero blanking (LZB = 1):
  - Digit k (k > 0) displays 1111111 when digit k and every higher digit are 0.
  - control still selects that digit.
- No combinational path exists from any input to y, control, bcd or carry.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - The SEG_* active-low segment constants for 0–9 and SEG_BLANK.
  - The function seg_decode (4-bit code → 7 bits). It returns SEG_BLANK for codes > 9.
- One natural sub-module, bcd_digit: a single decade cell.
  - Inputs: inc, dec, load, load_d.
  - Outputs: d[3:0], co (at 9 while incrementing), bo (at 0 while decrementing).
  - The top level instantiates DIGITS copies and chains co/bo into the next cell's inc/dec.
- The prescalers and the scan mux stay in the top level.

Test Plan:
All scenarios use DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless a parameter is stated.
- Reset release, en=0: bcd = 0000, control = 1110, y = 1000000. After 2 clk, control = 1101; after 8 clk, control = 1110 again. bcd is stable throughout.
- en=1, up_dn=1, load 9998: one tick later bcd = 9999, carry = 0. Next tick bcd = 0000 and carry is high for exactly 1 clk. Ticks occur every 4 clk.
- en=1, up_dn=0, load 1000: next tick bcd = 0999. Load 0000 then tick: bcd = 9999 with a carry pulse.
- load 12F7 (hex, digit 1 invalid) with tick on the same edge: bcd = 1207, no increment, carry = 0. Prescaler reads 0 on the next cycle.
- en toggled low for 10 clk mid-prescale: the tick arrives exactly (4 − prescaler value at the stall) enabled cycles later; bcd does not step during the stall.
- LZB=1, bcd = 0040: digits 3 and 2 display 1111111, digit 1 displays 0011001 (4), digit 0 displays 1000000. Reassert rst_n low mid-scan: all outputs return to reset values immediately, without waiting for clk.
